// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

    // Controller state: normal flow, or holding a multiply in EX.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // Default total EX occupancy of a multiply, in cycles.
    localparam int unsigned MUL_LAT_DEF = 4;

    // Width of the multiply down-counter for the default latency.
    localparam int unsigned CNT_W = $clog2(MUL_LAT_DEF);

    // Architectural zero register; never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating count of stalled pipeline cycles.
module stall_perf_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on each stalled cycle, holding once all ones is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: multi-cycle multiply in EX,
// load-use bubbles and MEM-stage branch redirects.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned STALL_CW = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          Branch,
    input  logic                IDEX_MemRead,
    input  logic                IDEX_RegWrite,
    input  logic                IDEX_MulOp,
    input  logic [4:0]          IDEX_Rt,
    input  logic [4:0]          IFID_Rs,
    input  logic [4:0]          IFID_Rt,
    output logic                PCWrite,
    output logic                IFIDWrite,
    output logic                IDEXWrite,
    output logic                IFIDFlush,
    output logic                IDEXFlush,
    output logic                EXMEMFlush,
    output logic                MulBusy,
    output logic [STALL_CW-1:0] StallCycles
);

    // Counter width sized for this instance's latency (max load value MUL_LAT-2).
    localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 2);

    state_t        state;
    logic [CW-1:0] cnt;

    logic redirect;
    logic mul_entry;
    logic load_use;

    assign redirect  = (Branch != 2'b00);
    assign mul_entry = (state == RUN) && IDEX_MulOp && IDEX_RegWrite;
    assign load_use  = load_use_hit(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt);

    // Prioritised Mealy decode of the write enables and flush strobes.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        if (!Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (redirect) begin
            // Everything younger than the branch, including a pending multiply, dies.
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (mul_entry || ((state == MUL_WAIT) && (cnt != '0))) begin
            // Freeze front end and EX; feed bubbles into MEM behind the multiply.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
        end else if (state == MUL_WAIT) begin
            // Release cycle: multiply advances to MEM with default strobes.
        end else if (load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // FSM: hold a multiply in EX for MUL_LAT cycles; redirects always win.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (redirect) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mul_entry) begin
            state <= MUL_WAIT;
            cnt   <= CNT_LOAD;
        end else if (state == MUL_WAIT) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                state <= RUN;
            end
        end
    end

    assign MulBusy = (state == MUL_WAIT);

    stall_perf_counter #(
        .WIDTH (STALL_CW)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (~PCWrite),
        .count (StallCycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: default instance plus a small
// saturating-counter instance (MUL_LAT=16, STALL_CW=4) sharing the inputs.
module tb_pipe_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] Branch;
    logic       IDEX_MemRead, IDEX_RegWrite, IDEX_MulOp;
    logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;

    logic        pcw1, ifidw1, idexw1, ifidf1, idexf1, exmemf1, mb1;
    logic [15:0] cnt1;
    logic        pcw2, ifidw2, idexw2, ifidf2, idexf2, exmemf2, mb2;
    logic [3:0]  cnt2;

    logic [6:0] s1_obs, s2_obs;
    assign s1_obs = {pcw1, ifidw1, idexw1, ifidf1, idexf1, exmemf1, mb1};
    assign s2_obs = {pcw2, ifidw2, idexw2, ifidf2, idexf2, exmemf2, mb2};

    // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulBusy}
    localparam logic [6:0] NORM = 7'b1110000;
    localparam logic [6:0] STL0 = 7'b0000010;
    localparam logic [6:0] STL1 = 7'b0000011;
    localparam logic [6:0] LU   = 7'b0010100;
    localparam logic [6:0] BR0  = 7'b1111110;
    localparam logic [6:0] BR1  = 7'b1111111;
    localparam logic [6:0] REL  = 7'b1110001;
    localparam logic [6:0] RSTV = 7'b0001110;

    pipe_stall_ctrl #(.MUL_LAT(4), .STALL_CW(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .Branch(Branch),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MulOp(IDEX_MulOp),
        .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .PCWrite(pcw1), .IFIDWrite(ifidw1), .IDEXWrite(idexw1),
        .IFIDFlush(ifidf1), .IDEXFlush(idexf1), .EXMEMFlush(exmemf1),
        .MulBusy(mb1), .StallCycles(cnt1)
    );

    pipe_stall_ctrl #(.MUL_LAT(16), .STALL_CW(4)) u_sat (
        .Clk(Clk), .Reset(Reset), .Branch(Branch),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MulOp(IDEX_MulOp),
        .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .PCWrite(pcw2), .IFIDWrite(ifidw2), .IDEXWrite(idexw2),
        .IFIDFlush(ifidf2), .IDEXFlush(idexf2), .EXMEMFlush(exmemf2),
        .MulBusy(mb2), .StallCycles(cnt2)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        chk1;
        logic [6:0]  s1;
        logic [15:0] c1;
        logic        chk2;
        logic [6:0]  s2;
        logic [3:0]  c2;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_stall1;
    logic [3:0]  m_stall2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] br, input logic mr, input logic rw, input logic mo,
                         input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt);
        Branch        = br;
        IDEX_MemRead  = mr;
        IDEX_RegWrite = rw;
        IDEX_MulOp    = mo;
        IDEX_Rt       = ex_rt;
        IFID_Rs       = rs;
        IFID_Rt       = rt;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // One cycle: push expectation at drive time (posedge+1), pop at negedge.
    task automatic step(input string tag, input logic chk1, input logic [6:0] s1,
                        input logic chk2, input logic [6:0] s2);
        exp_t e;
        e = '{chk1: chk1, s1: s1, c1: m_stall1, chk2: chk2, s2: s2, c2: m_stall2};
        sb_q.push_back(e);
        @(negedge Clk);
        e = sb_q.pop_front();
        if (e.chk1) begin
            check({tag, "_strb"}, 32'(s1_obs), 32'(e.s1));
            check({tag, "_cnt"},  32'(cnt1),   32'(e.c1));
            if (!e.s1[6]) m_stall1 = m_stall1 + 16'd1;
        end
        if (e.chk2) begin
            check({tag, "_strb2"}, 32'(s2_obs), 32'(e.s2));
            check({tag, "_cnt2"},  32'(cnt2),   32'(e.c2));
            if (!e.s2[6] && m_stall2 != 4'hf) m_stall2 = m_stall2 + 4'd1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        idle();
        #1;
        check("rst_strb",  32'(s1_obs), 32'(RSTV));
        check("rst_cnt",   32'(cnt1),   32'd0);
        check("rst_strb2", 32'(s2_obs), 32'(RSTV));
        check("rst_cnt2",  32'(cnt2),   32'd0);
        m_stall1 = '0;
        m_stall2 = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_stall1 = '0;
        m_stall2 = '0;
        do_reset();
        idle();
        step("idle", 1, NORM, 0, NORM);

        // Load-use via Rs, then via Rt, then $0 and non-matching loads.
        drive(2'b00, 1, 0, 0, 5'd5, 5'd5, 5'd9);
        step("lu_rs", 1, LU, 0, NORM);
        idle();
        step("lu_after", 1, NORM, 0, NORM);
        check("lu_count", 32'(cnt1), 32'd1);
        drive(2'b00, 1, 0, 0, 5'd7, 5'd3, 5'd7);
        step("lu_rt", 1, LU, 0, NORM);
        drive(2'b00, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("lu_r0", 1, NORM, 0, NORM);
        drive(2'b00, 1, 0, 0, 5'd6, 5'd5, 5'd4);
        step("lu_miss", 1, NORM, 0, NORM);
        drive(2'b00, 0, 1, 0, 5'd5, 5'd5, 5'd5);
        step("lu_noload", 1, NORM, 0, NORM);
        // Multiply without RegWrite is not held.
        drive(2'b00, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step("mul_norw", 1, NORM, 0, NORM);

        // Single multiply: stalls t..t+2, release t+3.
        drive(2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        step("mul_t0", 1, STL0, 0, NORM);
        step("mul_t1", 1, STL1, 0, NORM);
        step("mul_t2", 1, STL1, 0, NORM);
        step("mul_rel", 1, REL, 0, NORM);
        idle();
        step("mul_done", 1, NORM, 0, NORM);
        check("mul_count", 32'(cnt1), 32'd5);

        // Branch kills a multiply in MUL_WAIT with cnt=1.
        drive(2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        step("brk_t0", 1, STL0, 0, NORM);
        step("brk_t1", 1, STL1, 0, NORM);
        drive(2'b01, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        step("brk_br", 1, BR1, 0, NORM);
        idle();
        step("brk_after", 1, NORM, 0, NORM);
        // Branch beats a load-use in RUN.
        drive(2'b10, 1, 0, 0, 5'd5, 5'd5, 5'd0);
        step("br_lu", 1, BR0, 0, NORM);

        // Back-to-back multiplies.
        do_reset();
        drive(2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            step("b2b_s0", 1, STL0, 0, NORM);
            step("b2b_s1", 1, STL1, 0, NORM);
            step("b2b_s2", 1, STL1, 0, NORM);
            step("b2b_rel", 1, REL, 0, NORM);
        end
        idle();
        step("b2b_done", 1, NORM, 0, NORM);
        check("b2b_count", 32'(cnt1), 32'd6);

        // Asynchronous reset in the middle of MUL_WAIT.
        drive(2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        step("ar_t0", 1, STL0, 0, NORM);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("ar_strb", 32'(s1_obs), 32'(RSTV));
        check("ar_cnt",  32'(cnt1),   32'd0);
        m_stall1 = '0;
        m_stall2 = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle();
        step("ar_after", 1, NORM, 0, NORM);
        step("ar_after2", 1, NORM, 0, NORM);

        // Saturation on the MUL_LAT=16, 4-bit counter instance.
        do_reset();
        drive(2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            int pos;
            logic [6:0] s2;
            pos = i % 16;
            s2  = (pos == 15) ? REL : ((pos == 0) ? STL0 : STL1);
            step("sat", 0, NORM, 1, s2);
        end
        idle();
        step("sat_idle", 0, NORM, 1, NORM);
        check("sat_final", 32'(cnt2), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
